// File: rtl/fir_symm_tdm.sv
// Symmetric-coefficient FIR filter built around one time-shared pre-adder, multiplier and
// accumulator, with run-time loadable coefficients and rounding/saturating output.
module fir_symm_tdm #(
  parameter  int unsigned DW    = 10,
  parameter  int unsigned CW    = 10,
  parameter  int unsigned NTAPS = 5,
  parameter  int unsigned OW    = 20,
  parameter  int unsigned SHIFT = 0,
  localparam int unsigned H     = (NTAPS + 1) / 2,
  localparam int unsigned TW    = (H > 1) ? $clog2(H) : 1
) (
  input  logic                 clk,
  input  logic                 rst_x,
  input  logic                 clk_en,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] filter_in,
  output logic                 out_valid,
  output logic signed [OW-1:0] filter_out,
  input  logic                 coef_wr,
  input  logic [TW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 coef_err
);

  localparam int unsigned AW = DW + 1 + CW + $clog2(H);
  localparam int unsigned PW = CW + DW + 1;
  localparam int unsigned EW = (AW + 1 > OW) ? AW + 1 : OW + 1;

  localparam logic signed [EW-1:0] RndK = (SHIFT > 0) ? (EW'(1) << (SHIFT - 1)) : '0;
  localparam logic signed [EW-1:0] MaxV = {{(EW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [EW-1:0] MinV = {{(EW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e               r_state;
  logic signed [DW-1:0] r_x [NTAPS];
  logic signed [CW-1:0] r_coef [H];
  logic signed [AW-1:0] r_acc;
  logic [TW-1:0]        r_tap;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_coef_err;
  logic signed [OW-1:0] r_filter_out;

  logic                 w_accept;
  logic                 w_coef_ok;
  logic signed [DW-1:0] w_xa;
  logic signed [DW-1:0] w_xb;
  logic signed [CW-1:0] w_c;
  logic                 w_mid;
  logic signed [DW:0]   w_pre;
  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_prod_ext;
  logic signed [EW-1:0] w_rnd;
  logic signed [EW-1:0] w_shf;
  logic signed [OW-1:0] w_sat;

  assign w_accept  = in_valid & r_in_ready;
  assign w_coef_ok = (r_state == StIdle) && !w_accept && ({1'b0, coef_addr} < (TW + 1)'(H));

  // Select the mirrored sample pair and coefficient for the current tap.
  always_comb begin
    w_xa  = '0;
    w_xb  = '0;
    w_c   = '0;
    w_mid = 1'b0;
    for (int k = 0; k < int'(H); k++) begin
      if (r_tap == TW'(k)) begin
        w_xa  = r_x[k];
        w_xb  = r_x[int'(NTAPS) - 1 - k];
        w_c   = r_coef[k];
        w_mid = ((NTAPS % 2) == 1) && (k == int'(H) - 1);
      end
    end
  end

  // Centre tap of an odd-length filter is used once, not doubled.
  assign w_pre      = w_mid ? {w_xa[DW-1], w_xa}
                            : {w_xa[DW-1], w_xa} + {w_xb[DW-1], w_xb};
  assign w_prod     = PW'(w_c) * PW'(w_pre);
  assign w_prod_ext = AW'(w_prod);

  assign w_rnd = EW'(r_acc) + RndK;
  assign w_shf = w_rnd >>> SHIFT;
  assign w_sat = (w_shf > MaxV) ? MaxV[OW-1:0] :
                 (w_shf < MinV) ? MinV[OW-1:0] : w_shf[OW-1:0];

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_state      <= StIdle;
      r_acc        <= '0;
      r_tap        <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_coef_err   <= 1'b0;
      r_filter_out <= '0;
      for (int k = 0; k < int'(NTAPS); k++) r_x[k] <= '0;
      for (int k = 0; k < int'(H); k++) r_coef[k] <= '0;
    end else if (clk_en) begin
      r_coef_err <= coef_wr & ~w_coef_ok;
      if (coef_wr && w_coef_ok) r_coef[coef_addr] <= coef_data;
      if (clr) begin
        // Flush history and any result in flight; coefficients survive.
        r_state     <= StIdle;
        r_acc       <= '0;
        r_tap       <= '0;
        r_in_ready  <= 1'b1;
        r_out_valid <= 1'b0;
        for (int k = 0; k < int'(NTAPS); k++) r_x[k] <= '0;
      end else begin
        r_out_valid <= 1'b0;
        unique case (r_state)
          StIdle: begin
            if (w_accept) begin
              r_x[0] <= filter_in;
              for (int k = 1; k < int'(NTAPS); k++) r_x[k] <= r_x[k-1];
              r_acc      <= '0;
              r_tap      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= StMac;
            end
          end
          StMac: begin
            r_acc <= r_acc + w_prod_ext;
            r_tap <= r_tap + 1'b1;
            if (r_tap == TW'(H - 1)) r_state <= StOut;
          end
          StOut: begin
            r_filter_out <= w_sat;
            r_out_valid  <= 1'b1;
            r_in_ready   <= 1'b1;
            r_state      <= StIdle;
          end
          default: begin
            r_in_ready <= 1'b1;
            r_state    <= StIdle;
          end
        endcase
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign filter_out = r_filter_out;
  assign coef_err   = r_coef_err;

endmodule
